// File: rtl/grid_stream_loader.sv
// Converts a raw puzzle text byte stream into WIDTH-bit row bitmaps written one row per cycle,
// and records the column of the 'S' start marker.
module grid_stream_loader #(
    parameter int WIDTH  = 141,
    parameter int HEIGHT = 141,
    parameter int COL_W  = 8,
    parameter int ROW_W  = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [7:0]       in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             row_we,
    output logic [ROW_W-1:0] row_addr,
    output logic [WIDTH-1:0] row_data,
    output logic [COL_W-1:0] start_col,
    output logic             start_found,
    output logic             done,
    output logic             error,
    output logic [1:0]       err_code
);

    typedef enum logic [1:0] {IDLE, LOAD, DONE, ERROR} state_t;

    state_t           state, state_nx;
    logic [COL_W-1:0] col;
    logic [ROW_W-1:0] row;
    logic [WIDTH-1:0] shreg;

    logic accept, last_pending, col_full, col_zero;
    logic is_dot, is_hat, is_s, is_cr, is_lf, is_data;
    logic commit, fault;
    logic [1:0] fcode;

    // The final row's write cycle blocks input so completion lands exactly one cycle later.
    assign last_pending = row_we && (row_addr == ROW_W'(HEIGHT - 1));
    assign in_ready     = (state == LOAD) && !last_pending;
    assign accept       = in_valid && in_ready;
    assign col_full     = (col == COL_W'(WIDTH));
    assign col_zero     = (col == '0);

    assign is_dot  = (in_data == 8'h2E);
    assign is_hat  = (in_data == 8'h5E);
    assign is_s    = (in_data == 8'h53);
    assign is_cr   = (in_data == 8'h0D);
    assign is_lf   = (in_data == 8'h0A);
    assign is_data = is_dot || is_hat || is_s;

    always_comb begin
        commit = 1'b0;
        fault  = 1'b0;
        fcode  = 2'd0;
        if (accept) begin
            if (is_data) begin
                if (col_full) begin
                    fault = 1'b1;
                    fcode = 2'd2;
                end else if (is_s && start_found) begin
                    fault = 1'b1;
                    fcode = 2'd3;
                end
            end else if (is_lf) begin
                if (col_full) begin
                    commit = 1'b1;
                end else if (!col_zero) begin
                    fault = 1'b1;
                    fcode = 2'd2;
                end
            end else if (!is_cr) begin
                fault = 1'b1;
                fcode = 2'd1;
            end
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE, DONE, ERROR: if (start) state_nx = LOAD;
            LOAD: begin
                if (fault)             state_nx = ERROR;
                else if (last_pending) state_nx = DONE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col         <= '0;
            row         <= '0;
            shreg       <= '0;
            row_we      <= 1'b0;
            row_addr    <= '0;
            row_data    <= '0;
            start_col   <= '0;
            start_found <= 1'b0;
            done        <= 1'b0;
            error       <= 1'b0;
            err_code    <= '0;
        end else begin
            row_we <= commit && !fault;
            if (state != LOAD) begin
                if (start) begin
                    col         <= '0;
                    row         <= '0;
                    shreg       <= '0;
                    start_col   <= '0;
                    start_found <= 1'b0;
                    done        <= 1'b0;
                    error       <= 1'b0;
                    err_code    <= '0;
                end
            end else if (fault) begin
                error    <= 1'b1;
                err_code <= fcode;
            end else if (last_pending) begin
                done <= 1'b1;
            end else if (commit) begin
                row_addr <= row;
                row_data <= shreg;
                row      <= row + 1'b1;
                col      <= '0;
                shreg    <= '0;
            end else if (accept && is_data) begin
                // First character of a line ends up in the MSB after WIDTH shifts.
                shreg <= {shreg[WIDTH-2:0], is_hat};
                col   <= col + 1'b1;
                if (is_s) begin
                    start_col   <= col;
                    start_found <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_grid_stream_loader.sv
// Directed bench for grid_stream_loader: a small 5x3 instance for protocol/fault cases
// and a default 141x141 instance for a full-size grid, both checked against a text-level model.
module tb_grid_stream_loader;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [7:0] din = '0;
    logic       valid = 1'b0;
    logic       sel = 1'b0;

    logic         s_ready, s_we, s_sf, s_done, s_err;
    logic [3:0]   s_addr, s_sc;
    logic [4:0]   s_data;
    logic [1:0]   s_code;
    logic         b_ready, b_we, b_sf, b_done, b_err;
    logic [7:0]   b_addr, b_sc;
    logic [140:0] b_data;
    logic [1:0]   b_code;

    always #5 clk = ~clk;

    grid_stream_loader #(.WIDTH(5), .HEIGHT(3), .COL_W(4), .ROW_W(4)) dut_s (
        .clk(clk), .rst(rst), .start(start), .in_data(din), .in_valid(valid && !sel),
        .in_ready(s_ready), .row_we(s_we), .row_addr(s_addr), .row_data(s_data),
        .start_col(s_sc), .start_found(s_sf), .done(s_done), .error(s_err), .err_code(s_code)
    );

    grid_stream_loader dut_b (
        .clk(clk), .rst(rst), .start(start), .in_data(din), .in_valid(valid && sel),
        .in_ready(b_ready), .row_we(b_we), .row_addr(b_addr), .row_data(b_data),
        .start_col(b_sc), .start_found(b_sf), .done(b_done), .error(b_err), .err_code(b_code)
    );

    logic         m_ready, m_we, m_sf, m_done, m_err;
    logic [7:0]   m_addr, m_sc;
    logic [140:0] m_data;
    logic [1:0]   m_code;
    assign m_ready = sel ? b_ready : s_ready;
    assign m_we    = sel ? b_we    : s_we;
    assign m_sf    = sel ? b_sf    : s_sf;
    assign m_done  = sel ? b_done  : s_done;
    assign m_err   = sel ? b_err   : s_err;
    assign m_code  = sel ? b_code  : s_code;
    assign m_addr  = sel ? b_addr  : 8'(s_addr);
    assign m_sc    = sel ? b_sc    : 8'(s_sc);
    assign m_data  = sel ? b_data  : 141'(s_data);

    int n_cmp = 0;
    int n_bad = 0;

    function automatic void chk(input string name, input logic [191:0] got, input logic [191:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endfunction

    // Model state: expected writes and end-of-load status derived from the text.
    byte          stream[$];
    int           exp_addr[$];
    logic [140:0] exp_data[$];
    int           got_addr[$];
    logic [140:0] got_data[$];
    bit           e_done, e_err, e_sf;
    logic [1:0]   e_code;
    int           e_sc;
    int           cur_h = 3;
    bit           mon_on = 1'b0;
    bit           prev_final = 1'b0;

    task automatic load_str(input string s);
        stream.delete();
        for (int i = 0; i < s.len(); i++) stream.push_back(s[i]);
    endtask

    task automatic build_model(input int w, input int h);
        int           col;
        int           rows;
        logic [140:0] bits;
        col = 0; rows = 0; bits = '0;
        exp_addr.delete(); exp_data.delete();
        e_done = 0; e_err = 0; e_sf = 0; e_code = 0; e_sc = 0;
        foreach (stream[i]) begin
            if (e_done || e_err) break;
            case (stream[i])
                8'h2E, 8'h5E, 8'h53: begin
                    if (col >= w) begin
                        e_err = 1; e_code = 2;
                    end else if (stream[i] == 8'h53 && e_sf) begin
                        e_err = 1; e_code = 3;
                    end else begin
                        if (stream[i] == 8'h5E) bits[w-1-col] = 1'b1;
                        if (stream[i] == 8'h53) begin e_sf = 1; e_sc = col; end
                        col++;
                    end
                end
                8'h0D: ;
                8'h0A: begin
                    if (col == w) begin
                        exp_addr.push_back(rows);
                        exp_data.push_back(bits);
                        rows++; col = 0; bits = '0;
                        if (rows == h) e_done = 1;
                    end else if (col != 0) begin
                        e_err = 1; e_code = 2;
                    end
                end
                default: begin e_err = 1; e_code = 1; end
            endcase
        end
    endtask

    always @(negedge clk) begin
        if (!mon_on) begin
            prev_final <= 1'b0;
        end else begin
            if (prev_final) chk("done_latency", {m_done, m_ready}, 2'b10);
            prev_final <= m_we && (int'(m_addr) == cur_h - 1);
            if (m_we) begin
                got_addr.push_back(int'(m_addr));
                got_data.push_back(m_data);
                if (exp_addr.size() == 0) begin
                    chk("extra_row_we", {m_addr, m_data}, '0);
                end else begin
                    chk("row_write", {m_addr, m_data}, {8'(exp_addr.pop_front()), exp_data.pop_front()});
                end
            end
            if (m_done || m_err) chk("ready_when_stopped", m_ready, 0);
        end
    end

    task automatic do_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("after_start", {m_done, m_err, m_code, m_sf, m_sc, m_ready}, {1'b0, 1'b0, 2'b00, 1'b0, 8'h00, 1'b1});
    endtask

    task automatic send(input bit gaps);
        int t;
        foreach (stream[i]) begin
            if (gaps) begin
                valid = 1'b0;
                repeat ($urandom_range(1)) @(negedge clk);
            end
            valid = 1'b1;
            din = stream[i];
            t = 0;
            while (!m_ready) begin
                if (m_done || m_err) begin
                    valid = 1'b0;
                    return;
                end
                if (t == 50) begin
                    n_cmp++; n_bad++;
                    $display("FAIL handshake_timeout: got no in_ready expected in_ready within 50 cycles");
                    valid = 1'b0;
                    return;
                end
                @(negedge clk);
                t++;
            end
            @(negedge clk);
        end
        valid = 1'b0;
    endtask

    task automatic run(input int w, input int h, input bit gaps);
        cur_h = h;
        build_model(w, h);
        got_addr.delete(); got_data.delete();
        do_start();
        send(gaps);
        repeat (4) @(negedge clk);
        chk("final_status", {m_done, m_err, m_code, m_sf, m_sc, m_ready},
            {e_done, e_err, e_code, e_sf, 8'(e_sc), !(e_done || e_err)});
        chk("writes_remaining", exp_addr.size(), 0);
        if (e_err) begin
            valid = 1'b1; din = 8'h2E;
            repeat (4) begin
                chk("ready_in_error", m_ready, 0);
                @(negedge clk);
            end
            valid = 1'b0;
        end
    endtask

    localparam string SCEN1 = "..S..\n..^..\n.^.^.\n";

    initial begin
        #1000000;
        $display("FAIL watchdog: got no completion expected completion before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        chk("reset_state", {s_we, s_addr, s_data, s_sc, s_sf, s_done, s_err, s_code, s_ready}, '0);
        rst = 1'b0;
        @(negedge clk);
        mon_on = 1'b1;

        load_str(SCEN1);
        run(5, 3, 0);
        chk("scen1_rows", {got_addr.size(), got_data[0], got_data[1], got_data[2]},
            {32'd3, 141'h00, 141'h04, 141'h0A});
        chk("scen1_start", {s_sc, s_sf, s_done}, {4'd2, 1'b1, 1'b1});

        load_str("\n..S..\015\n..^..\015\n.^.^.\015\n\n\n");
        run(5, 3, 0);

        load_str("..S..\n..x..\n");
        run(5, 3, 0);
        chk("illegal_char", {s_err, s_code, 32'(got_addr.size())}, {1'b1, 2'd1, 32'd1});

        load_str("..S..\n..^.\n");
        run(5, 3, 0);
        chk("short_row", {s_err, s_code}, {1'b1, 2'd2});

        load_str("......");
        run(5, 3, 0);
        chk("long_row", {s_err, s_code, 32'(got_addr.size())}, {1'b1, 2'd2, 32'd0});

        load_str("..S..\n..^..\n.^S^.\n");
        run(5, 3, 0);
        chk("dup_s", {s_err, s_code, 32'(got_addr.size())}, {1'b1, 2'd3, 32'd2});

        load_str(SCEN1);
        run(5, 3, 1);
        chk("gaps_rows", got_addr.size(), 3);

        load_str("..S..\n..");
        build_model(5, 3);
        do_start();
        send(0);
        @(negedge clk);
        #2 rst = 1'b1;
        #1 chk("reset_mid_load", {s_we, s_addr, s_data, s_sc, s_sf, s_done, s_err, s_code, s_ready}, '0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        load_str(SCEN1);
        run(5, 3, 0);
        chk("after_reset_rows", {got_addr.size(), got_addr[0], got_data[1]}, {32'd3, 32'd0, 141'h04});

        sel = 1'b1;
        stream.delete();
        for (int r = 0; r < 141; r++) begin
            for (int c = 0; c < 141; c++) begin
                if (r == 0 && c == 70)                  stream.push_back(8'h53);
                else if (r > 0 && (r * 3 + c) % 11 == 0) stream.push_back(8'h5E);
                else                                    stream.push_back(8'h2E);
            end
            stream.push_back(8'h0A);
        end
        cur_h = 141;
        build_model(141, 141);
        got_addr.delete(); got_data.delete();
        do_start();
        send(0);
        repeat (4) @(negedge clk);
        chk("big_status", {b_done, b_err, b_sf, b_sc}, {1'b1, 1'b0, 1'b1, 8'd70});
        chk("big_count", {got_addr.size(), exp_addr.size()}, {32'd141, 32'd0});
        chk("big_row0", got_data[0], '0);
        chk("big_row1_bits", {got_data[1][140], got_data[1][132], got_data[1][0]}, 3'b011);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
